// File: rtl/c2_host_initiator.sv
`timescale 1ns/1ps
// c2_host_initiator: host side of the C2 command protocol. It sends a command
// byte over UART TX, checks the target's echo, then either streams a loader
// payload or collects the response stream. The outcome is reported on done/err.
// Ports: cmd_* (request in), pay_* (payload source), uart_tx_*/uart_rx_* (UART
// core), rsp_* (collected bytes), busy/done/err/err_code (status).
// Latency: accept->tx_start 1 cycle, final event->done 1 cycle; PAY_REQ stalls freely.
module c2_host_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  input  logic [7:0]  cmd_i,
  input  logic [15:0] len_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  pay_data_i,
  input  logic        pay_valid_i,
  output logic        pay_ready_o,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_start_o,
  input  logic        uart_tx_done_i,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_ready_i,
  output logic [7:0]  rsp_data_o,
  output logic        rsp_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD_TX, S_CMD_WAIT, S_ECHO_WAIT, S_PAY_REQ,
    S_PAY_TX, S_PAY_WAIT, S_RSP, S_DONE
  } state_e;

  localparam logic [1:0] CODE_OK   = 2'b00;
  localparam logic [1:0] CODE_ILL  = 2'b01;
  localparam logic [1:0] CODE_ECHO = 2'b10;
  localparam logic [1:0] CODE_TMO  = 2'b11;

  // Counter value on the last permitted idle cycle; at this value with no
  // event the FSM gives up.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [15:0]      len_q, len_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             pend_vld_q, pend_vld_d;
  logic [7:0]       pend_dat_q, pend_dat_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic [1:0]       err_code_q, err_code_d;

  logic        tmo_exp;
  logic [15:0] len_dec;
  logic        echo_vld;
  logic [7:0]  echo_dat;
  logic        cmd_legal;
  logic        cmd_is_load;
  logic        timed_state;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    tmo_d      = tmo_q;
    tx_data_d  = tx_data_q;
    pend_vld_d = 1'b0;
    pend_dat_d = pend_dat_q;
    rsp_data_d = rsp_data_q;
    rsp_vld_d  = 1'b0;
    err_code_d = err_code_q;

    tmo_exp     = (tmo_q == TMO_LAST);
    len_dec     = (len_q == 16'd0) ? 16'd0 : len_q - 16'd1;
    cmd_legal   = (cmd_i == 8'h1C) || (cmd_i == 8'h1D) ||
                  (cmd_i == 8'hCE) || (cmd_i == 8'hDE);
    cmd_is_load = (cmd_q == 8'h1C) || (cmd_q == 8'h1D);
    // An echo captured during CMD_WAIT takes priority over a live RX byte.
    echo_vld    = pend_vld_q | uart_rx_ready_i;
    echo_dat    = pend_vld_q ? pend_dat_q : uart_rx_data_i;
    timed_state = (state_q == S_CMD_WAIT) || (state_q == S_ECHO_WAIT) ||
                  (state_q == S_PAY_WAIT) || (state_q == S_RSP);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_legal) begin
            cmd_d     = cmd_i;
            len_d     = len_i;
            tx_data_d = cmd_i;
            state_d   = S_CMD_TX;
          end else begin
            err_code_d = CODE_ILL;
            state_d    = S_DONE;
          end
        end
      end
      S_CMD_TX: state_d = S_CMD_WAIT;
      S_CMD_WAIT: begin
        // A fast loopback echo may arrive before (or with) tx_done.
        pend_vld_d = pend_vld_q | uart_rx_ready_i;
        if (uart_rx_ready_i && !pend_vld_q) pend_dat_d = uart_rx_data_i;
        if (uart_tx_done_i) begin
          state_d = S_ECHO_WAIT;
        end else if (tmo_exp) begin
          err_code_d = CODE_TMO;
          state_d    = S_DONE;
        end
      end
      S_ECHO_WAIT: begin
        if (echo_vld) begin
          if (echo_dat != cmd_q) begin
            err_code_d = CODE_ECHO;
            state_d    = S_DONE;
          end else if (len_q == 16'd0) begin
            err_code_d = CODE_OK;
            state_d    = S_DONE;
          end else begin
            state_d = cmd_is_load ? S_PAY_REQ : S_RSP;
          end
        end else if (tmo_exp) begin
          err_code_d = CODE_TMO;
          state_d    = S_DONE;
        end
      end
      S_PAY_REQ: begin
        if (pay_valid_i) begin
          tx_data_d = pay_data_i;
          state_d   = S_PAY_TX;
        end
      end
      S_PAY_TX: state_d = S_PAY_WAIT;
      S_PAY_WAIT: begin
        if (uart_tx_done_i) begin
          len_d = len_dec;
          if (len_dec == 16'd0) begin
            err_code_d = CODE_OK;
            state_d    = S_DONE;
          end else begin
            state_d = S_PAY_REQ;
          end
        end else if (tmo_exp) begin
          err_code_d = CODE_TMO;
          state_d    = S_DONE;
        end
      end
      S_RSP: begin
        if (uart_rx_ready_i) begin
          rsp_data_d = uart_rx_data_i;
          rsp_vld_d  = 1'b1;
          len_d      = len_dec;
          if (len_dec == 16'd0) begin
            err_code_d = CODE_OK;
            state_d    = S_DONE;
          end
        end else if (tmo_exp) begin
          err_code_d = CODE_TMO;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Idle-cycle counter restarts on every state change and on each
    // response byte, so it measures the gap since the last progress.
    if ((state_d != state_q) || ((state_q == S_RSP) && uart_rx_ready_i)) begin
      tmo_d = '0;
    end else if (timed_state) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cmd_q      <= 8'h00;
      len_q      <= 16'h0000;
      tmo_q      <= '0;
      tx_data_q  <= 8'h00;
      pend_vld_q <= 1'b0;
      pend_dat_q <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_vld_q  <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      tmo_q      <= tmo_d;
      tx_data_q  <= tx_data_d;
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
      rsp_data_q <= rsp_data_d;
      rsp_vld_q  <= rsp_vld_d;
      err_code_q <= err_code_d;
    end
  end

  assign cmd_ready_o     = (state_q == S_IDLE);
  assign busy_o          = (state_q != S_IDLE);
  assign uart_tx_start_o = (state_q == S_CMD_TX) || (state_q == S_PAY_TX);
  assign uart_tx_data_o  = tx_data_q;
  assign pay_ready_o     = (state_q == S_PAY_REQ);
  assign rsp_data_o      = rsp_data_q;
  assign rsp_valid_o     = rsp_vld_q;
  assign done_o          = (state_q == S_DONE);
  assign err_o           = (state_q == S_DONE) && (err_code_q != CODE_OK);
  assign err_code_o      = err_code_q;

endmodule

// File: tb/tb_c2_host_initiator.sv
`timescale 1ns/1ps
module tb_c2_host_initiator;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i, cmd_ready_o;
  logic [7:0]  cmd_i;
  logic [15:0] len_i;
  logic [7:0]  pay_data_i;
  logic        pay_valid_i, pay_ready_o;
  logic [7:0]  uart_tx_data_o;
  logic        uart_tx_start_o, uart_tx_done_i;
  logic [7:0]  uart_rx_data_i;
  logic        uart_rx_ready_i;
  logic [7:0]  rsp_data_o;
  logic        rsp_valid_o, busy_o, done_o, err_o;
  logic [1:0]  err_code_o;

  c2_host_initiator #(.TIMEOUT_CYCLES(100), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i), .len_i(len_i), .cmd_ready_o(cmd_ready_o),
    .pay_data_i(pay_data_i), .pay_valid_i(pay_valid_i), .pay_ready_o(pay_ready_o),
    .uart_tx_data_o(uart_tx_data_o), .uart_tx_start_o(uart_tx_start_o),
    .uart_tx_done_i(uart_tx_done_i), .uart_rx_data_i(uart_rx_data_i),
    .uart_rx_ready_i(uart_rx_ready_i), .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Model state: what the DUT must emit for the transactions planned so far.
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rsp[$];
  logic [1:0] exp_done[$];
  int         exp_done_cyc = -1;
  int         hs_cnt = 0;
  logic [7:0] pay_stim[$];
  logic [7:0] rx_stim[$];
  logic [1:0] cur_code;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Protocol-level model: from the command, the echo the target returns and
  // the stimulus bytes, derive the bytes sent, bytes collected and result code.
  task automatic plan(input logic [7:0] c, input logic [7:0] echo, input bit got_echo);
    bit legal;
    bit load;
    legal = (c == 8'h1C) || (c == 8'h1D) || (c == 8'hCE) || (c == 8'hDE);
    load  = (c == 8'h1C) || (c == 8'h1D);
    if (!legal) begin
      exp_done.push_back(2'b01);
      return;
    end
    exp_tx.push_back(c);
    if (!got_echo) exp_done.push_back(2'b11);
    else if (echo != c) exp_done.push_back(2'b10);
    else begin
      if (load) foreach (pay_stim[i]) exp_tx.push_back(pay_stim[i]);
      else      foreach (rx_stim[i])  exp_rsp.push_back(rx_stim[i]);
      exp_done.push_back(2'b00);
    end
  endtask

  // Single compare process against the model.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("ready_vs_busy", 32'(cmd_ready_o), 32'(!busy_o));
      if (pay_ready_o && pay_valid_i) hs_cnt++;
      if (uart_tx_start_o) begin
        check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) check("tx_byte", 32'(uart_tx_data_o), 32'(exp_tx.pop_front()));
      end
      if (rsp_valid_o) begin
        check("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
        if (exp_rsp.size() != 0) check("rsp_byte", 32'(rsp_data_o), 32'(exp_rsp.pop_front()));
      end
      if (done_o) begin
        check("done_expected", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) begin
          cur_code = exp_done.pop_front();
          check("done_code", 32'(err_code_o), 32'(cur_code));
          check("done_err", 32'(err_o), 32'(cur_code != 2'b00));
          if (exp_done_cyc >= 0) begin
            check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
            exp_done_cyc = -1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic [7:0] c, input logic [15:0] l);
    cmd_i = c; len_i = l; cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic pulse_done();
    uart_tx_done_i = 1'b1;
    tick();
    uart_tx_done_i = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    uart_rx_data_i = b; uart_rx_ready_i = 1'b1;
    tick();
    uart_rx_ready_i = 1'b0;
  endtask

  task automatic wait_pay_ready(input string nm);
    int n;
    n = 0;
    while (!pay_ready_o && n < 50) begin tick(); n++; end
    check({nm, "_pay_ready_seen"}, 32'(pay_ready_o), 32'd1);
  endtask

  task automatic send_pay(input logic [7:0] b);
    pay_data_i = b; pay_valid_i = 1'b1;
    tick();
    pay_valid_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    check({nm, "_tx_left"},   32'(exp_tx.size()),   32'd0);
    check({nm, "_rsp_left"},  32'(exp_rsp.size()),  32'd0);
    check({nm, "_done_left"}, 32'(exp_done.size()), 32'd0);
    check({nm, "_cyc_left"},  32'(exp_done_cyc),    32'hFFFF_FFFF);
    exp_tx.delete(); exp_rsp.delete(); exp_done.delete();
    exp_done_cyc = -1;
  endtask

  task automatic check_rst(input string nm);
    check({nm, "_cmd_ready"}, 32'(cmd_ready_o),     32'd1);
    check({nm, "_busy"},      32'(busy_o),          32'd0);
    check({nm, "_tx_start"},  32'(uart_tx_start_o), 32'd0);
    check({nm, "_tx_data"},   32'(uart_tx_data_o),  32'd0);
    check({nm, "_pay_ready"}, 32'(pay_ready_o),     32'd0);
    check({nm, "_rsp_valid"}, 32'(rsp_valid_o),     32'd0);
    check({nm, "_rsp_data"},  32'(rsp_data_o),      32'd0);
    check({nm, "_done"},      32'(done_o),          32'd0);
    check({nm, "_err"},       32'(err_o),           32'd0);
    check({nm, "_err_code"},  32'(err_code_o),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, m, hs0;
    cmd_valid_i = 0; cmd_i = 0; len_i = 0; pay_data_i = 0; pay_valid_i = 0;
    uart_tx_done_i = 0; uart_rx_data_i = 0; uart_rx_ready_i = 0;
    ticks(3);
    check_rst("reset");
    rst_ni = 1'b1;
    ticks(2);

    // Load code happy path, with a long payload stall and a stray RX byte.
    pay_stim = '{8'hAA, 8'hBB, 8'hCC};
    rx_stim.delete();
    plan(8'h1C, 8'h1C, 1'b1);
    hs0 = hs_cnt;
    issue(8'h1C, 16'd3);
    check("t1_start_at_n1", 32'(uart_tx_start_o), 32'd1);
    check("t1_busy_at_n1",  32'(busy_o),          32'd1);
    ticks(2);
    pulse_done();
    tick();
    pulse_rx(8'h1C);
    for (int i = 0; i < 3; i++) begin
      wait_pay_ready("t1");
      if (i == 1) ticks(120);
      send_pay(pay_stim[i]);
      check("t1_pay_start", 32'(uart_tx_start_o), 32'd1);
      tick();
      if (i == 0) pulse_rx(8'h1C);
      ticks(2);
      check("t1_no_ready_in_wait", 32'(pay_ready_o), 32'd0);
      if (i == 2) exp_done_cyc = cyc + 1;
      pulse_done();
    end
    ticks(2);
    check("t1_handshakes", 32'(hs_cnt - hs0), 32'd3);
    drain("t1");

    // Debug exec collecting four response bytes; RX in IDLE is ignored.
    pulse_rx(8'h5A);
    tick();
    pay_stim.delete();
    rx_stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    plan(8'hDE, 8'hDE, 1'b1);
    issue(8'hDE, 16'd4);
    tick();
    pulse_done();
    pulse_rx(8'hDE);
    for (int i = 0; i < 4; i++) begin
      ticks(2);
      if (i == 3) exp_done_cyc = cyc + 1;
      pulse_rx(rx_stim[i]);
    end
    check("t2_last_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("t2_last_rsp_data",  32'(rsp_data_o),  32'h04);
    check("t2_done_with_last", 32'(done_o),      32'd1);
    ticks(2);
    drain("t2");

    // Illegal command: immediate error, nothing transmitted.
    plan(8'h55, 8'h00, 1'b0);
    n = cyc;
    exp_done_cyc = n + 1;
    issue(8'h55, 16'd2);
    check("t3_done",     32'(done_o),     32'd1);
    check("t3_err",      32'(err_o),      32'd1);
    check("t3_code",     32'(err_code_o), 32'd1);
    ticks(3);
    check("t3_code_hold", 32'(err_code_o), 32'd1);
    check("t3_done_low",  32'(done_o),     32'd0);
    drain("t3");

    // Echo mismatch: payload offered but never taken.
    pay_stim = '{8'h99, 8'h98};
    plan(8'h1D, 8'h1C, 1'b1);
    hs0 = hs_cnt;
    pay_data_i = 8'h99; pay_valid_i = 1'b1;
    issue(8'h1D, 16'd2);
    tick();
    pulse_done();
    pulse_rx(8'h1C);
    ticks(3);
    pay_valid_i = 1'b0;
    check("t4_no_handshake", 32'(hs_cnt - hs0), 32'd0);
    check("t4_code",         32'(err_code_o),   32'd2);
    drain("t4");

    // Timeout: no echo, done exactly 100 cycles after ECHO_WAIT entry.
    pay_stim.delete(); rx_stim.delete();
    plan(8'hCE, 8'h00, 1'b0);
    issue(8'hCE, 16'd1);
    tick();
    m = cyc;
    exp_done_cyc = m + 101;
    pulse_done();
    ticks(105);
    check("t5_code", 32'(err_code_o), 32'd3);
    drain("t5");

    // Echo arriving on the expiry cycle wins over the timeout.
    rx_stim = '{8'h77};
    plan(8'hCE, 8'hCE, 1'b1);
    issue(8'hCE, 16'd1);
    tick();
    m = cyc;
    pulse_done();
    while (cyc < m + 100) tick();
    pulse_rx(8'hCE);
    ticks(3);
    check("t5b_still_busy", 32'(busy_o), 32'd1);
    exp_done_cyc = cyc + 1;
    pulse_rx(8'h77);
    ticks(2);
    check("t5b_code", 32'(err_code_o), 32'd0);
    drain("t5b");

    // Zero-length exec and zero-length load finish on the echo.
    rx_stim.delete();
    plan(8'hCE, 8'hCE, 1'b1);
    issue(8'hCE, 16'd0);
    tick();
    pulse_done();
    exp_done_cyc = cyc + 1;
    pulse_rx(8'hCE);
    ticks(2);
    drain("t6a");
    pay_stim.delete();
    plan(8'h1D, 8'h1D, 1'b1);
    hs0 = hs_cnt;
    pay_valid_i = 1'b1;
    issue(8'h1D, 16'd0);
    tick();
    pulse_done();
    exp_done_cyc = cyc + 1;
    pulse_rx(8'h1D);
    ticks(2);
    pay_valid_i = 1'b0;
    check("t6b_no_handshake", 32'(hs_cnt - hs0), 32'd0);
    drain("t6b");

    // Echo coincident with tx_done, then reset during PAY_WAIT.
    pay_stim = '{8'h11, 8'h22};
    plan(8'h1C, 8'h1C, 1'b1);
    issue(8'h1C, 16'd2);
    tick();
    uart_tx_done_i = 1'b1; uart_rx_ready_i = 1'b1; uart_rx_data_i = 8'h1C;
    tick();
    uart_tx_done_i = 1'b0; uart_rx_ready_i = 1'b0;
    wait_pay_ready("t7");
    send_pay(8'h11);
    ticks(3);
    check("t7_busy_in_wait", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_rst("t7");
    check("t7_tx_sent_before_reset", 32'(exp_tx.size()), 32'd1);
    exp_tx.delete(); exp_done.delete(); exp_done_cyc = -1;
    tick();
    rst_ni = 1'b1;
    ticks(2);
    plan(8'h00, 8'h00, 1'b0);
    exp_done_cyc = cyc + 1;
    issue(8'h00, 16'd0);
    ticks(2);
    drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
